frame_unstacker: RTL
====================

Name: frame_unstacker

Overview:
- Sits directly downstream of the DRAM read path, on the output side of the read AXIS FIFO, in the same clock domain as that FIFO's read port.
- Consumes 128-bit read words carrying a frame-end TLAST and emits 16-bit pixels as an AXI-Stream, one pixel per handshake.
- Locks onto frame boundaries and checks that TLAST arrives where it should.
- Drops data until it is aligned, then re-checks alignment every frame.

Parameters:
- FRAME_WORDS, 115200: number of 128-bit words per frame (1280x720 pixels / 8 pixels per word).
- PIX_PER_WORD, 8: fixed at 8; 16-bit pixels in a 128-bit word. Not overridable; lives in the package.

Ports:
- clk_in  input  1  block clock
- rst_in  input  1  synchronous active-high reset
- s_axis_data  input  128  packed pixels; pixel 0 in bits [15:0]
- s_axis_tlast  input  1  last word of a frame
- s_axis_valid  input  1  input word valid
- s_axis_ready  output  1  block accepts the input word
- m_axis_data  output  16  current pixel
- m_axis_tlast  output  1  last pixel of a frame
- m_axis_valid  output  1  pixel valid
- m_axis_ready  input  1  consumer accepts the pixel
- in_sync  output  1  high while in the RUN state
- frame_err  output  1  one-cycle pulse on any TLAST misalignment

Behaviour:
- Interface decision: one clock, clk_in; rst_in is synchronous and active-high.
- Reset values: state=SYNC, buf_valid=0, pix_idx=0, word_cnt=0.
  - Outputs under reset: m_axis_valid=0, m_axis_tlast=0, m_axis_data=0, in_sync=0, frame_err=0.
  - s_axis_ready follows the state equations below; in SYNC it is 1.
- Reset mid-frame discards the held word with no output. Input words already in flight are then dropped in SYNC.
- SYNC state:
  - s_axis_ready=1 and every input word is discarded; m_axis_valid=0.
  - An input handshake with s_axis_tlast=1 moves the block to RUN with word_cnt=0.
  - The TLAST word itself is discarded.
- RUN state:
  - s_axis_ready = !buf_valid || (m_axis_valid && m_axis_ready && pix_idx==7). This is a combinational path from m_axis_ready.
  - On an input handshake:
    - Latch the word into the buffer; buf_valid=1 next cycle; pix_idx=0.
    - Latch exp_last = (word_cnt==FRAME_WORDS-1).
    - Latch in_last = s_axis_tlast.
  - Load-to-first-pixel latency is 1 cycle.
  - m_axis_valid=buf_valid; m_axis_data = buf[pix_idx*16 +: 16].
  - pix_idx advances on each output handshake.
  - On the handshake at pix_idx==7:
    - buf_valid clears, unless a new word is loaded the same cycle.
    - word_cnt increments, or wraps to 0 when the word was a frame end.
  - Back-to-back words sustain one pixel per cycle with no bubble.
- Frame-end rule: m_axis_tlast = buf_valid && pix_idx==7 && (exp_last || in_last).
- Alignment check, evaluated on the final-pixel handshake of each word:
  - exp_last && in_last: normal frame end; word_cnt=0; stay in RUN.
  - in_last && !exp_last (early TLAST): frame_err pulses; word_cnt=0; stay in RUN, already re-aligned.
  - exp_last && !in_last (missing TLAST): frame_err pulses; go to SYNC and drop until the next input TLAST.
- word_cnt is ceil(log2(FRAME_WORDS)) bits wide and compared against FRAME_WORDS-1.
- in_sync = (state==RUN).
- m_axis_valid is held until handshake and m_axis_data is stable while valid and not ready (AXI-Stream rules).

Optional Feature:
- Macro: FRAME_UNSTACKER_ERR_CNT_EN.
- When defined:
  - Adds output port err_count [15:0], a saturating count of frame_err pulses.
  - The count resets to 0 on rst_in and holds at 16'hFFFF once reached.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package frame_unstacker_pkg holds:
  - typedef enum {SYNC, RUN} fu_state_t;
  - localparams PIXEL_W=16, WORD_W=128, PIX_PER_WORD=8.
- One natural sub-module: word_serializer. It contains the buffer, pix_idx, the valid/ready logic and last-pixel detection.
- The parent keeps the FSM, word_cnt and the alignment check.

Test Plan (all runs use FRAME_WORDS=4):
- Reset release, then 2 non-TLAST words followed by a TLAST word:
  - All three are dropped with m_axis_valid=0.
  - in_sync rises the cycle after the TLAST handshake.
- In sync, 4 words (TLAST on the 4th) with m_axis_ready=1 constantly:
  - 32 consecutive pixels, in order, word0[15:0] first.
  - m_axis_tlast only on pixel 32; no idle cycles after the first pixel.
- Same 4-word frame with m_axis_ready toggling 1/0:
  - m_axis_data stays stable while stalled.
  - No pixel is lost or duplicated.
  - s_axis_ready stays low until pixel 8 of the current word is accepted.
- TLAST on word 2 of 4:
  - m_axis_tlast on pixel 16; frame_err pulses once; in_sync stays 1.
  - The next word is output as word 0 of a new frame.
- No TLAST on word 4:
  - m_axis_tlast on pixel 32; frame_err pulses; in_sync falls.
  - Words are dropped until the next TLAST.
- With FRAME_UNSTACKER_ERR_CNT_EN defined, inject 3 misaligned frames then assert rst_in for one cycle:
  - err_count reads 3, then 0 after reset.
  - Mid-word reset clears m_axis_valid the next cycle.

Source files
------------

// File: rtl/frame_unstacker_pkg.sv
// frame_unstacker_pkg: shared widths and state type for the frame unstacker.
package frame_unstacker_pkg;

   localparam int unsigned PIXEL_W      = 16;
   localparam int unsigned WORD_W       = 128;
   localparam int unsigned PIX_PER_WORD = 8;
   localparam int unsigned IDX_W        = $clog2(PIX_PER_WORD);

   typedef enum logic [0:0] {
      SYNC = 1'b0,
      RUN  = 1'b1
   } fu_state_t;

endpackage

// File: rtl/frame_unstacker_word_serializer.sv
// frame_unstacker_word_serializer: holds one 128-bit word and streams it out
// as eight 16-bit pixels, pixel 0 from bits [15:0] first. Flags the frame-end
// pixel from the two last-word flags captured with the word.
module frame_unstacker_word_serializer
   import frame_unstacker_pkg::*;
(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               load,
   input  logic [WORD_W-1:0]  load_data,
   input  logic               load_exp_last,
   input  logic               load_in_last,
   output logic               load_ready,
   output logic [PIXEL_W-1:0] m_axis_data,
   output logic               m_axis_tlast,
   output logic               m_axis_valid,
   input  logic               m_axis_ready,
   output logic               word_done,
   output logic               word_exp_last,
   output logic               word_in_last
);

   logic [PIX_PER_WORD-1:0][PIXEL_W-1:0] buf_q;
   logic                                 buf_valid;
   logic [IDX_W-1:0]                     pix_idx;
   logic                                 exp_last_q;
   logic                                 in_last_q;
   logic                                 last_pix;
   logic                                 pix_hs;

   assign last_pix      = (pix_idx == IDX_W'(PIX_PER_WORD - 1));
   assign pix_hs        = buf_valid && m_axis_ready;
   assign word_done     = pix_hs && last_pix;
   // A new word may enter on the same cycle the final pixel leaves.
   assign load_ready    = !buf_valid || word_done;

   assign m_axis_valid  = buf_valid;
   assign m_axis_data   = buf_valid ? buf_q[pix_idx] : '0;
   assign m_axis_tlast  = buf_valid && last_pix && (exp_last_q || in_last_q);
   assign word_exp_last = exp_last_q;
   assign word_in_last  = in_last_q;

   // Buffer occupancy, pixel index and per-word last flags.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         buf_valid  <= 1'b0;
         pix_idx    <= '0;
         exp_last_q <= 1'b0;
         in_last_q  <= 1'b0;
      end else if (load) begin
         buf_valid  <= 1'b1;
         pix_idx    <= '0;
         exp_last_q <= load_exp_last;
         in_last_q  <= load_in_last;
      end else if (word_done) begin
         buf_valid  <= 1'b0;
         pix_idx    <= '0;
      end else if (pix_hs) begin
         pix_idx    <= pix_idx + 1'b1;
      end
   end

   // Word storage; contents are don't-care while the buffer is empty.
   always_ff @(posedge clk_in) begin
      if (load) begin
         buf_q <= load_data;
      end
   end

endmodule

// File: rtl/frame_unstacker.sv
// frame_unstacker: turns 128-bit frame words into a 16-bit pixel AXI-Stream,
// locks onto frame boundaries and checks TLAST placement every frame.
// Optional build macro FRAME_UNSTACKER_ERR_CNT_EN adds a saturating
// err_count output counting frame_err pulses.
module frame_unstacker
   import frame_unstacker_pkg::*;
#(
   parameter int unsigned FRAME_WORDS = 115200
)(
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [WORD_W-1:0]  s_axis_data,
   input  logic               s_axis_tlast,
   input  logic               s_axis_valid,
   output logic               s_axis_ready,
   output logic [PIXEL_W-1:0] m_axis_data,
   output logic               m_axis_tlast,
   output logic               m_axis_valid,
   input  logic               m_axis_ready,
   output logic               in_sync,
`ifdef FRAME_UNSTACKER_ERR_CNT_EN
   output logic [15:0]        err_count,
`endif
   output logic               frame_err
);

   localparam int unsigned    CNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

   fu_state_t        state;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_cnt_eff;
   logic             ser_ready;
   logic             word_done;
   logic             w_exp;
   logic             w_in;
   logic             missing_last;
   logic             s_hs;
   logic             load;

   assign missing_last = word_done && w_exp && !w_in;
   assign s_axis_ready = (state == SYNC) ? 1'b1 : ser_ready;
   assign s_hs         = s_axis_valid && s_axis_ready;
   // A word arriving alongside the final pixel of a word with missing TLAST
   // is treated as a SYNC-state word: dropped, and used to resync if TLAST.
   assign load         = s_hs && (state == RUN) && !missing_last;
   assign in_sync      = (state == RUN);

   // Word count as it stands after this cycle's word completion, so a word
   // loaded alongside the previous word's final pixel sees its true index.
   always_comb begin
      word_cnt_eff = word_cnt;
      if (word_done) begin
         if (w_exp || w_in) begin
            word_cnt_eff = '0;
         end else begin
            word_cnt_eff = word_cnt + 1'b1;
         end
      end
   end

   frame_unstacker_word_serializer u_ser (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .load          (load),
      .load_data     (s_axis_data),
      .load_exp_last (word_cnt_eff == LAST_CNT),
      .load_in_last  (s_axis_tlast),
      .load_ready    (ser_ready),
      .m_axis_data   (m_axis_data),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_valid  (m_axis_valid),
      .m_axis_ready  (m_axis_ready),
      .word_done     (word_done),
      .word_exp_last (w_exp),
      .word_in_last  (w_in)
   );

   // Frame lock FSM, word counter and alignment check.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state     <= SYNC;
         word_cnt  <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            SYNC: begin
               if (s_hs && s_axis_tlast) begin
                  state    <= RUN;
                  word_cnt <= '0;
               end
            end
            RUN: begin
               if (word_done) begin
                  word_cnt <= word_cnt_eff;
                  if (w_exp != w_in) begin
                     frame_err <= 1'b1;
                  end
                  if (missing_last && !(s_hs && s_axis_tlast)) begin
                     state <= SYNC;
                  end
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

`ifdef FRAME_UNSTACKER_ERR_CNT_EN
   // Saturating count of alignment errors.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         err_count <= '0;
      end else if (frame_err && (err_count != '1)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule
